spi_bus_master: RTL



---
 rtl/spi_bus_master_pkg.sv | 23 ++
 rtl/spi_bus_master_if.sv | 24 ++
 rtl/spi_bus_master_edge_sync.sv | 32 +++
 rtl/spi_bus_master.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_master_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_bm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WR_DATA,
    RD_WAIT,
    RD_DATA
  } spi_bm_state_t;

  // Idle read address; chosen to fall outside every BAR window
  localparam logic [15:0] PARK_ADDR   = 16'hFFFF;
  localparam int          WORD_BITS   = 16;
  localparam int          WR_FLAG_BIT = 0;
  localparam int          ERR_CNT_W   = 8;

  // Saturating increment for the abort counter
  function automatic logic [ERR_CNT_W-1:0] satInc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_bus_master_if.sv
// Internal register bus driven by the SPI bridge and shared by all BAR-decoded slaves.
interface spi_bus_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] rdaddr;
  logic [ADDR_W-1:0] wraddr;
  logic [1:0]        be;
  logic              write;
  logic [DATA_W-1:0] wrdata;
  logic [DATA_W-1:0] rddata;

  modport master (
    output rdaddr, wraddr, be, write, wrdata,
    input  rddata
  );

  modport slave (
    input  rdaddr, wraddr, be, write, wrdata,
    output rddata
  );

endinterface

// File: rtl/spi_bus_master_edge_sync.sv
// Brings one asynchronous SPI pin into the clk domain and flags its edges.
module spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic aclr_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Synchronizer chain plus one flop holding the previous settled level for edge detection
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_bus_master.sv
// SPI mode-0 slave towards the host MCU that masters the internal register bus.
// Frames are a header {addr[15:1], wr} followed by write words or prefetched read words.
// Optional feature macro: SPI_BM_STATUS_EN (status word {~nirq, 0, err_cnt} on miso during header).
module spi_bus_master #(
  parameter int              ADDR_W      = 16,
  parameter int              DATA_W      = 16,
  parameter int              RD_LAT      = 2,
  parameter int              SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] PARK_ADDR = spi_bm_pkg::PARK_ADDR
) (
  input  logic                clk,
  input  logic                aclr_n,
  input  logic                sclk_i,
  input  logic                csn_i,
  input  logic                mosi_i,
  input  logic                nirq_i,
  output logic                miso_o,
  output logic                frame_err_o,
  spi_bus_master_if.master    bus
);

  import spi_bm_pkg::*;

  localparam logic [3:0]        LAST_BIT  = 4'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

  logic sclkSync, sclkRise, sclkFall;
  logic csnSync, csnRise, csnFall;
  logic mosiSync, mosiRise, mosiFall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSclkSync (
    .clk(clk), .aclr_n(aclr_n), .async_i(sclk_i),
    .sync_o(sclkSync), .rise_o(sclkRise), .fall_o(sclkFall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uCsnSync (
    .clk(clk), .aclr_n(aclr_n), .async_i(csn_i),
    .sync_o(csnSync), .rise_o(csnRise), .fall_o(csnFall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uMosiSync (
    .clk(clk), .aclr_n(aclr_n), .async_i(mosi_i),
    .sync_o(mosiSync), .rise_o(mosiRise), .fall_o(mosiFall)
  );

  spi_bm_state_t     state_q;
  logic [3:0]        bitCnt_q;
  logic [3:0]        latCnt_q;
  logic [DATA_W-1:0] shiftIn_q;
  logic [DATA_W-1:0] shiftOut_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rdaddr_q;
  logic [ADDR_W-1:0] wraddr_q;
  logic [DATA_W-1:0] wrdata_q;
  logic [1:0]        be_q;
  logic              write_q;
  logic              miso_q;
  logic              frameErr_q;

  logic [DATA_W-1:0] wordIn_d;
  logic [ADDR_W-1:0] hdrAddr_d;
  logic [DATA_W-1:0] statusWord;
  logic              lastBit;
  logic              wrComplete;
  logic              abortErr;
  logic              unusedSync;

  assign unusedSync = ^{sclkSync, csnSync, mosiRise, mosiFall};

  assign wordIn_d   = {shiftIn_q[DATA_W-2:0], mosiSync};
  assign hdrAddr_d  = {wordIn_d[ADDR_W-1:1], 1'b0};
  assign lastBit    = sclkRise && (bitCnt_q == LAST_BIT);
  assign wrComplete = (state_q == WR_DATA) && lastBit;
  // A word finishing on the same clk as csn rise is complete, so it is not an abort
  assign abortErr   = csnRise && (state_q != IDLE) &&
                      ((state_q == HDR) || ((bitCnt_q != 4'd0) && !lastBit));

`ifdef SPI_BM_STATUS_EN
  logic [ERR_CNT_W-1:0] errCnt_q;

  // Saturating count of aborted frames, reported to the host in the status word
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      errCnt_q <= '0;
    end else if (abortErr) begin
      errCnt_q <= satInc(errCnt_q);
    end
  end

  assign statusWord = {~nirq_i, {(DATA_W-1-ERR_CNT_W){1'b0}}, errCnt_q};
`else
  logic unusedNirq;
  assign unusedNirq = nirq_i;
  assign statusWord = '0;
`endif

  // Frame FSM: header decode, write strobes, read prefetch and miso shifting
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      latCnt_q   <= '0;
      shiftIn_q  <= '0;
      shiftOut_q <= '0;
      addr_q     <= '0;
      rdaddr_q   <= PARK_ADDR;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      miso_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      write_q    <= 1'b0;
      be_q       <= 2'b00;
      frameErr_q <= 1'b0;
      if (wrComplete) begin
        write_q  <= 1'b1;
        be_q     <= 2'b11;
        wraddr_q <= addr_q;
        wrdata_q <= wordIn_d;
        addr_q   <= addr_q + ADDR_STEP;
      end
      if (csnRise) begin
        frameErr_q <= abortErr;
        state_q    <= IDLE;
        rdaddr_q   <= PARK_ADDR;
        miso_q     <= 1'b0;
        shiftOut_q <= '0;
        bitCnt_q   <= '0;
      end else if (state_q == IDLE) begin
        if (csnFall) begin
          state_q    <= HDR;
          bitCnt_q   <= '0;
          miso_q     <= statusWord[DATA_W-1];
          shiftOut_q <= {statusWord[DATA_W-2:0], 1'b0};
        end
      end else begin
        if (sclkRise) begin
          bitCnt_q  <= bitCnt_q + 4'd1;
          shiftIn_q <= wordIn_d;
        end
        if (sclkFall) begin
          miso_q     <= shiftOut_q[DATA_W-1];
          shiftOut_q <= {shiftOut_q[DATA_W-2:0], 1'b0};
        end
        case (state_q)
          HDR: begin
            if (lastBit) begin
              addr_q <= hdrAddr_d;
              if (wordIn_d[WR_FLAG_BIT]) begin
                state_q <= WR_DATA;
              end else begin
                state_q  <= RD_WAIT;
                rdaddr_q <= hdrAddr_d;
                latCnt_q <= '0;
              end
            end
          end
          RD_WAIT: begin
            if (latCnt_q == 4'(RD_LAT)) begin
              shiftOut_q <= bus.rddata;
              addr_q     <= addr_q + ADDR_STEP;
              rdaddr_q   <= addr_q + ADDR_STEP;
              state_q    <= RD_DATA;
            end else begin
              latCnt_q <= latCnt_q + 4'd1;
            end
          end
          RD_DATA: begin
            if (lastBit) begin
              shiftOut_q <= bus.rddata;
              addr_q     <= addr_q + ADDR_STEP;
              rdaddr_q   <= addr_q + ADDR_STEP;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign miso_o      = miso_q;
  assign frame_err_o = frameErr_q;
  assign bus.rdaddr  = rdaddr_q;
  assign bus.wraddr  = wraddr_q;
  assign bus.be      = be_q;
  assign bus.write   = write_q;
  assign bus.wrdata  = wrdata_q;

endmodule
